apb_master: RTL and testbench
=============================

# apb_master

APB initiator that converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers and returns one response per command. It sits between on-chip control logic (or a sequencer) and APB peripherals such as the UART register block, replacing task-driven bus stimulus with synthesizable hardware. Wait states are honoured via PREADY. A programmable timeout aborts transfers to unresponsive slaves.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max ACCESS cycles per transfer before abort; 0 disables timeout
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_addr  in  ADDR_W  target address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_W  read data (0 for writes and aborts)
- rsp_err  out  1  1 = transfer aborted by timeout
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB slave ready

## Operation
- States: IDLE, SETUP, ACCESS. Reset state IDLE.
- cmd_ready = (state == IDLE), decoded from the state register; never depends on cmd_valid.
- IDLE: on cmd_valid && cmd_ready, register cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA, set PSEL=1, go SETUP.
- SETUP: set PENABLE=1, clear wait counter, go ACCESS. Always exactly one cycle.
- ACCESS with PREADY=1: clear PSEL and PENABLE; rsp_valid=1, rsp_err=0, rsp_rdata = PWRITE ? 0 : PRDATA; go IDLE.
- ACCESS with PREADY=0: increment wait counter; if TIMEOUT != 0 and counter == TIMEOUT-1, abort: clear PSEL and PENABLE, rsp_valid=1, rsp_err=1, rsp_rdata=0, go IDLE.
- PREADY=1 in the final permitted cycle wins: normal completion, rsp_err=0.
- Wait counter width $clog2(TIMEOUT+1), minimum 1; it never wraps because abort occurs first.
- PADDR, PWRITE, PWDATA hold their last values after a transfer; they change only on command acceptance.
- rsp_valid lasts exactly one cycle. rsp_rdata and rsp_err hold until the next response.
- Commands presented while cmd_ready=0 are neither captured nor lost; the source must hold them.

## Timing
- Reset (asynchronous, immediate): PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE. cmd_ready=1 after reset.
- Command accepted at edge k: PSEL=1 after k, PENABLE=1 after k+1. PREADY is sampled at k+2 and later.
- Zero-wait transfer: PSEL high for 2 cycles, PENABLE high for 1 cycle, rsp_valid high in the cycle after edge k+2.
- With n wait states, PENABLE is high for n+1 cycles and the response shifts by n cycles.
- Throughput: the next command can be accepted at edge k+3 (zero-wait case), so a back-to-back transfer takes at least 3 cycles. rsp_valid of transfer N coincides with cmd_ready=1 for transfer N+1.
- Reset asserted mid-transfer: the bus drops immediately and no response is issued for the cut transfer.

## Test plan
- Write 0x0000_FFFF to 0x04 with PREADY tied 1 -> PADDR=0x04, PWRITE=1, PWDATA=0xFFFF. PSEL is high for 2 cycles and PENABLE for 1. One rsp_valid pulse with rsp_err=0 and rsp_rdata=0.
- Read 0x08 with PREADY low for 2 ACCESS cycles and PRDATA=0xA5A5_0001 -> PENABLE is high for 3 cycles. rsp_rdata=0xA5A5_0001, rsp_err=0.
- TIMEOUT=4, read with PREADY held 0 -> abort after 4 ACCESS cycles. PSEL and PENABLE go 0, with rsp_valid=1, rsp_err=1, rsp_rdata=0. The next command is accepted normally.
- TIMEOUT=4, PREADY rises in the 4th ACCESS cycle -> normal completion with rsp_err=0.
- cmd_valid held high across two queued commands with PREADY=1 -> the second is accepted exactly 3 cycles after the first. cmd_ready=0 during SETUP/ACCESS, and PADDR is unchanged until the second acceptance.
- PRESETn pulsed low during ACCESS -> all outputs go 0 with no clock edge, and no rsp_valid is issued. After release, cmd_ready=1 and a new read completes correctly.

Source files
------------

// File: rtl/apb_master_if.sv
// apb_master_if: bundles the command/response stream and the APB3 bus of the
// apb_master block.
//   master modport : view of the APB initiator (drives APB request signals,
//                    cmd_ready and the response; reads commands, PRDATA, PREADY)
//   slave modport  : view of the surrounding environment (command source,
//                    response sink and APB peripheral side)
// Signal names follow the APB3 and command-stream naming used by the block.
interface apb_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // Command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  logic [DATA_W-1:0] cmd_wdata;

  // Response stream (no backpressure)
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // APB3 bus
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    input  PRDATA, PREADY,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    output PRDATA, PREADY,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

endinterface

// File: rtl/apb_master.sv
// apb_master: APB3 initiator. Accepts one command at a time from a
// valid/ready stream, runs it as a SETUP + ACCESS transfer (honouring PREADY
// wait states) and returns exactly one single-cycle response per command.
// A transfer whose slave never raises PREADY is aborted after TIMEOUT ACCESS
// cycles and answered with rsp_err=1 (TIMEOUT=0 waits forever).
//
// Ports
//   PCLK     in  clock, all logic on the rising edge
//   PRESETn  in  asynchronous active-low reset
//   bus      apb_master_if.master
//              cmd_valid/cmd_ready/cmd_addr/cmd_write/cmd_wdata : command in
//              rsp_valid/rsp_rdata/rsp_err                      : response out
//              PADDR/PWRITE/PSEL/PENABLE/PWDATA/PRDATA/PREADY   : APB3 bus
module apb_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  apb_master_if.master  bus
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value seen in the last permitted ACCESS cycle.
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic              pwrite_q,    pwrite_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic [CW-1:0]     wait_q,      wait_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    wait_d      = wait_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        // cmd_ready is 1 in IDLE, so cmd_valid alone means acceptance.
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (bus.PREADY) begin
          // Completion takes priority over the timeout in the last cycle.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          state_d     = S_IDLE;
        end else if ((TIMEOUT != 0) && (wait_q == LAST)) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_IDLE;
        end else if (TIMEOUT != 0) begin
          wait_d = wait_q + CW'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master (TIMEOUT=4).
module tb_apb_master;

  logic PCLK;
  logic PRESETn;

  int tests_run;
  int tests_failed;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Present one command just after a rising edge and drop it right after the
  // edge that accepts it. On return, the next negedge is index 0 (after k).
  task automatic drive_cmd(input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata);
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_write = wr;
    bus.cmd_wdata = wdata;
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    #3;
    tests_run++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got PSEL=%b PENABLE=%b PWRITE=%b rsp_valid=%b rsp_err=%b, expected all 0",
               bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err);
    end
    tests_run++;
    if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== 96'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got PADDR=%h PWDATA=%h rsp_rdata=%h, expected 0",
               bus.PADDR, bus.PWDATA, bus.rsp_rdata);
    end
    #9 PRESETn = 1'b1;
    @(negedge PCLK);
    tests_run++;
    if (bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait;
    int psel_n = 0, pen_n = 0, rsp_n = 0, rsp_idx = -1;
    logic [31:0] rdata = 32'hDEAD_BEEF;
    logic err = 1'bx;
    bus.PREADY = 1'b1;
    drive_cmd(32'h04, 1'b1, 32'h0000_FFFF);
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      if (i == 0) begin
        tests_run++;
        if ({bus.PADDR, bus.PWRITE, bus.PWDATA} !== {32'h04, 1'b1, 32'h0000_FFFF}) begin
          tests_failed++;
          $display("FAIL wr_bus_fields: got PADDR=%h PWRITE=%b PWDATA=%h expected 00000004 1 0000ffff",
                   bus.PADDR, bus.PWRITE, bus.PWDATA);
        end
      end
      if (bus.PSEL) psel_n++;
      if (bus.PENABLE) pen_n++;
      if (bus.rsp_valid) begin
        rsp_n++; rsp_idx = i; rdata = bus.rsp_rdata; err = bus.rsp_err;
      end
    end
    tests_run++;
    if (psel_n !== 2 || pen_n !== 1) begin
      tests_failed++;
      $display("FAIL wr_psel_penable_len: got %0d/%0d expected 2/1", psel_n, pen_n);
    end
    tests_run++;
    if (rsp_n !== 1 || rsp_idx !== 2) begin
      tests_failed++;
      $display("FAIL wr_rsp_timing: got %0d pulses at idx %0d expected 1 at idx 2", rsp_n, rsp_idx);
    end
    tests_run++;
    if (rdata !== 32'h0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_rsp_value: got rdata=%h err=%b expected 00000000 0", rdata, err);
    end
  endtask

  task automatic test_read_wait;
    int pen_n = 0, rsp_idx = -1;
    logic [31:0] rdata = '0;
    logic err = 1'bx;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hA5A5_0001;
    drive_cmd(32'h08, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (bus.PENABLE) pen_n++;
      if (bus.rsp_valid) begin
        rsp_idx = i; rdata = bus.rsp_rdata; err = bus.rsp_err;
      end
      // Edge k+1+i follows; PREADY low for ACCESS edges k+2, k+3.
      bus.PREADY = (i >= 3);
    end
    tests_run++;
    if (pen_n !== 3) begin
      tests_failed++;
      $display("FAIL rd_wait_penable_len: got %0d expected 3", pen_n);
    end
    tests_run++;
    if (rsp_idx !== 4 || rdata !== 32'hA5A5_0001 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_wait_rsp: got idx=%0d rdata=%h err=%b expected 4 a5a50001 0",
               rsp_idx, rdata, err);
    end
  endtask

  task automatic test_timeout;
    int pen_n = 0, rsp_idx = -1;
    logic [31:0] rdata = 32'hFFFF_FFFF;
    logic err = 1'bx;
    logic bus_after = 1'bx;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h1111_2222;
    drive_cmd(32'h0C, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (bus.PENABLE) pen_n++;
      if (bus.rsp_valid) begin
        rsp_idx = i; rdata = bus.rsp_rdata; err = bus.rsp_err;
        bus_after = bus.PSEL | bus.PENABLE;
      end
    end
    tests_run++;
    if (pen_n !== 4 || rsp_idx !== 5) begin
      tests_failed++;
      $display("FAIL timeout_len: got penable=%0d rsp_idx=%0d expected 4 5", pen_n, rsp_idx);
    end
    tests_run++;
    if (err !== 1'b1 || rdata !== 32'h0 || bus_after !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_rsp: got err=%b rdata=%h psel|penable=%b expected 1 00000000 0",
               err, rdata, bus_after);
    end
    // Next command after an abort is handled normally.
    bus.PREADY = 1'b1;
    rsp_idx = -1; err = 1'bx;
    drive_cmd(32'h10, 1'b1, 32'h0000_0055);
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) begin rsp_idx = i; err = bus.rsp_err; end
    end
    tests_run++;
    if (rsp_idx !== 2 || err !== 1'b0 || bus.PADDR !== 32'h10) begin
      tests_failed++;
      $display("FAIL timeout_recover: got idx=%0d err=%b PADDR=%h expected 2 0 00000010",
               rsp_idx, err, bus.PADDR);
    end
  endtask

  task automatic test_timeout_boundary;
    int pen_n = 0, rsp_idx = -1;
    logic [31:0] rdata = '0;
    logic err = 1'bx;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h1234_5678;
    drive_cmd(32'h14, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (bus.PENABLE) pen_n++;
      if (bus.rsp_valid) begin
        rsp_idx = i; rdata = bus.rsp_rdata; err = bus.rsp_err;
      end
      // PREADY high only at the 4th ACCESS edge (k+5) onwards.
      bus.PREADY = (i >= 4);
    end
    tests_run++;
    if (rsp_idx !== 5 || err !== 1'b0 || rdata !== 32'h1234_5678 || pen_n !== 4) begin
      tests_failed++;
      $display("FAIL timeout_boundary: got idx=%0d err=%b rdata=%h penable=%0d expected 5 0 12345678 4",
               rsp_idx, err, rdata, pen_n);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] rdy;
    logic rsp2;
    logic [31:0] addr2;
    int rsp_b = -1;
    bus.PREADY = 1'b1;
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h20;
    bus.cmd_write = 1'b1;
    bus.cmd_wdata = 32'hAAAA_0000;
    @(posedge PCLK); #1;             // edge k: A accepted
    bus.cmd_addr  = 32'h24;          // B queued, cmd_valid stays high
    bus.cmd_wdata = 32'hBBBB_0000;
    @(negedge PCLK); rdy[0] = bus.cmd_ready;
    @(negedge PCLK); rdy[1] = bus.cmd_ready;
    @(negedge PCLK); rdy[2] = bus.cmd_ready; rsp2 = bus.rsp_valid; addr2 = bus.PADDR;
    tests_run++;
    if (rdy !== 3'b100) begin
      tests_failed++;
      $display("FAIL b2b_cmd_ready: got idx2..0=%b expected 100", rdy);
    end
    tests_run++;
    if (rsp2 !== 1'b1 || addr2 !== 32'h20) begin
      tests_failed++;
      $display("FAIL b2b_rsp_overlap: got rsp_valid=%b PADDR=%h expected 1 00000020", rsp2, addr2);
    end
    @(posedge PCLK); #1;             // edge k+3: B accepted
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    tests_run++;
    if (bus.PADDR !== 32'h24 || bus.PWDATA !== 32'hBBBB_0000 || bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second_accept: got PADDR=%h PWDATA=%h PSEL=%b PENABLE=%b expected 00000024 bbbb0000 1 0",
               bus.PADDR, bus.PWDATA, bus.PSEL, bus.PENABLE);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid && rsp_b < 0) rsp_b = i;
    end
    tests_run++;
    if (rsp_b !== 1) begin
      tests_failed++;
      $display("FAIL b2b_second_rsp: got idx %0d expected 1", rsp_b);
    end
  endtask

  task automatic test_reset_mid_transfer;
    int rsp_n = 0, rsp_idx = -1;
    logic [31:0] rdata = '0;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h0BAD_0BAD;
    drive_cmd(32'h30, 1'b0, 32'h0);
    @(negedge PCLK);                 // SETUP
    @(negedge PCLK);                 // ACCESS
    tests_run++;
    if (bus.PENABLE !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_precond: got PENABLE=%b expected 1", bus.PENABLE);
    end
    #2 PRESETn = 1'b0;
    #1;
    tests_run++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.cmd_ready} !== 6'b000001 ||
        {bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== 96'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got PSEL=%b PENABLE=%b rsp_valid=%b cmd_ready=%b PADDR=%h expected 0 0 0 1 00000000",
               bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready, bus.PADDR);
    end
    bus.PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) rsp_n++;
    end
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) rsp_n++;
    end
    tests_run++;
    if (rsp_n !== 0 || bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_no_rsp: got %0d pulses cmd_ready=%b expected 0 1", rsp_n, bus.cmd_ready);
    end
    bus.PRDATA = 32'hCAFE_0003;
    drive_cmd(32'h34, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) begin rsp_idx = i; rdata = bus.rsp_rdata; end
    end
    tests_run++;
    if (rsp_idx !== 2 || rdata !== 32'hCAFE_0003 || bus.rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_recover: got idx=%0d rdata=%h err=%b expected 2 cafe0003 0",
               rsp_idx, rdata, bus.rsp_err);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_timeout_boundary();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
